// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
//   - Access size encodings carried on req_size.
//   - FSM state enumeration used by load_store_unit.
//   - is_misaligned(): decides whether a request can reach the RAM at all.
package load_store_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } lsu_state_t;

    // Illegal size encodings are reported the same way as misalignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ls_align.sv
// Byte-lane alignment for the load/store unit (purely combinational).
// Ports:
//   i_size       access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   i_signed     sign-extend sub-word load results
//   i_lane       byte offset within the word (addr[1:0])
//   i_word       word read from RAM (little-endian, lane 0 = lowest address)
//   i_wdata      right-justified store data
//   o_load_data  extracted and extended load result
//   o_merge_data word to write back: i_word with the addressed lane(s) replaced
module ls_align
    import load_store_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    input  logic [1:0]        i_lane,
    input  logic [DATA_W-1:0] i_word,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_load_data,
    output logic [DATA_W-1:0] o_merge_data
);

    logic [4:0]  w_byte_ofs;
    logic [4:0]  w_half_ofs;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // A half access only uses addr[1]; addr[0] is known to be 0 here.
    assign w_byte_ofs = {i_lane, 3'b000};
    assign w_half_ofs = {i_lane[1], 4'b0000};
    assign w_byte     = i_word[w_byte_ofs +: 8];
    assign w_half     = i_word[w_half_ofs +: 16];

    always_comb begin
        o_load_data = i_word;
        case (i_size)
            SZ_BYTE: o_load_data = {{(DATA_W-8){i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = {{(DATA_W-16){i_signed & w_half[15]}}, w_half};
            default: o_load_data = i_word;
        endcase
    end

    always_comb begin
        o_merge_data = i_word;
        case (i_size)
            SZ_BYTE: o_merge_data[w_byte_ofs +: 8]  = i_wdata[7:0];
            SZ_HALF: o_merge_data[w_half_ofs +: 16] = i_wdata[15:0];
            default: o_merge_data = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding master for a word-wide, byte-addressed,
// little-endian RAM with combinational read and clocked write.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_we, req_size, req_signed     store/load, size, sign-extend loads
//   req_addr, req_wdata              byte address, right-justified store data
//   resp_valid, resp_err, resp_rdata one-cycle completion with status/data
//   mem_addr, mem_wr_en, mem_wr_data RAM word address and write port
//   mem_rd_data                      RAM combinational read data
//
// state | meaning
// IDLE  | ready for a request; capture fields on accept
// READ  | register RAM word (load data, or old word for sub-word store)
// WRITE | one-cycle RAM write (full word or merged word)
// RESP  | one-cycle completion pulse, then back to IDLE
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    lsu_state_t        r_state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rd_word;

    lsu_state_t        w_next_state;
    logic              w_accept;
    logic              w_req_mis;
    logic              w_cap_mis;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_merge_data;

    assign w_accept  = req_valid && (r_state == IDLE);
    assign w_req_mis = is_misaligned(req_size, req_addr[1:0]);
    assign w_cap_mis = is_misaligned(r_size, r_addr[1:0]);
    assign mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};

    ls_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .i_size      (r_size),
        .i_signed    (r_signed),
        .i_lane      (r_addr[1:0]),
        .i_word      (r_rd_word),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merge_data(w_merge_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_size    <= 2'b00;
            r_signed  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd_word <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_we     <= req_we;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
            if (r_state == READ) begin
                r_rd_word <= mem_rd_data;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_err     = 1'b0;
        resp_rdata   = '0;
        mem_wr_en    = 1'b0;
        mem_wr_data  = '0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_req_mis)
                        w_next_state = RESP;
                    else if (!req_we)
                        w_next_state = READ;
                    else if (req_size == SZ_WORD)
                        w_next_state = WRITE;
                    else
                        w_next_state = READ;   // sub-word store needs the old word
                end
            end
            READ: begin
                w_next_state = r_we ? WRITE : RESP;
            end
            WRITE: begin
                mem_wr_en    = 1'b1;
                mem_wr_data  = w_merge_data;
                w_next_state = RESP;
            end
            RESP: begin
                resp_valid   = 1'b1;
                resp_err     = w_cap_mis;
                resp_rdata   = (w_cap_mis || r_we) ? '0 : w_load_data;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [7:0]  mem_addr;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    logic [7:0] ram     [0:255];
    logic [7:0] ref_ram [0:255];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    // RAM attached to the DUT: combinational read, write on the clock edge.
    assign mem_rd_data = {ram[{mem_addr[7:2], 2'd3}], ram[{mem_addr[7:2], 2'd2}],
                          ram[{mem_addr[7:2], 2'd1}], ram[{mem_addr[7:2], 2'd0}]};

    always @(posedge clk) begin
        if (mem_wr_en) begin
            ram[{mem_addr[7:2], 2'd0}] <= mem_wr_data[7:0];
            ram[{mem_addr[7:2], 2'd1}] <= mem_wr_data[15:8];
            ram[{mem_addr[7:2], 2'd2}] <= mem_wr_data[23:16];
            ram[{mem_addr[7:2], 2'd3}] <= mem_wr_data[31:24];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: byte-array memory plus the latency/error rules of the unit.
    task automatic model(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [7:0] a, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd, output int lat,
                         output int nwr, output logic [31:0] wword);
        int nb;
        int base;
        nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err   = (sz == 2'd3) || ((int'(a) % nb) != 0);
        rd    = 32'd0;
        nwr   = 0;
        wword = 32'd0;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            for (int i = 0; i < nb; i++) rd = rd | (32'(ref_ram[int'(a) + i]) << (8 * i));
            if (sgn && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8 * nb));
        end else begin
            lat = (nb == 4) ? 2 : 3;
            for (int i = 0; i < nb; i++) ref_ram[int'(a) + i] = wd[8*i +: 8];
            nwr  = 1;
            base = int'(a) & 'hFC;
            for (int i = 0; i < 4; i++) wword[8*i +: 8] = ref_ram[base + i];
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn,
                          input logic [7:0] a, input logic [31:0] wd, input string tag,
                          output logic [31:0] got_rd, output int waitn);
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat;
        int          e_nwr;
        logic [31:0] e_wword;
        int          lat;
        int          nwr;
        logic [31:0] wword;
        bit          done;
        got_rd = 32'd0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = a;
        req_wdata  = wd;
        waitn = 0;
        while (!req_ready && waitn < 10) begin
            @(negedge clk);
            waitn++;
        end
        if (!req_ready) begin
            chk({tag, "_ready"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        model(we, sz, sgn, a, wd, e_err, e_rd, e_lat, e_nwr, e_wword);
        @(posedge clk); #1;
        lat   = 1;
        nwr   = 0;
        wword = 32'd0;
        done  = 1'b0;
        while (!done) begin
            if (mem_wr_en) begin
                nwr++;
                wword = mem_wr_data;
            end
            if (resp_valid || lat >= 6) begin
                done = 1'b1;
            end else begin
                chk({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
                // junk requests while busy must be ignored
                req_valid  = 1'b1;
                req_we     = 1'($urandom);
                req_size   = 2'($urandom);
                req_signed = 1'($urandom);
                req_addr   = 8'($urandom);
                req_wdata  = $urandom;
                @(posedge clk); #1;
                lat++;
            end
        end
        req_valid = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_err"}, 32'(resp_err), 32'(e_err));
        chk({tag, "_rdata"}, resp_rdata, e_rd);
        chk({tag, "_addr"}, 32'(mem_addr), 32'({a[7:2], 2'b00}));
        chk({tag, "_nwr"}, 32'(nwr), 32'(e_nwr));
        if (e_nwr != 0) chk({tag, "_wword"}, wword, e_wword);
        got_rd = resp_rdata;
    endtask

    logic [31:0] g;
    int          w;
    int          seen;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 8'h00;
        req_wdata  = 32'h0;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'($urandom);
            ref_ram[i] = ram[i];
        end
        ram[8'h10] = 8'h11; ram[8'h11] = 8'h82; ram[8'h12] = 8'h33; ram[8'h13] = 8'hF4;
        for (int i = 16; i < 20; i++) ref_ram[i] = ram[i];

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req(1'b0, SZ_BYTE, 1'b1, 8'h11, 32'h0, "ld_b_s", g, w);
        chk("ld_b_s_val", g, 32'hFFFF_FF82);
        do_req(1'b0, SZ_HALF, 1'b0, 8'h12, 32'h0, "ld_h_u", g, w);
        chk("ld_h_u_val", g, 32'h0000_F433);
        do_req(1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0, "ld_w", g, w);
        chk("ld_w_val", g, 32'hF433_8211);
        do_req(1'b1, SZ_BYTE, 1'b0, 8'h13, 32'h1234_56AB, "st_b", g, w);
        do_req(1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0, "ld_w2", g, w);
        chk("ld_w2_val", g, 32'hAB33_8211);

        do_req(1'b1, SZ_HALF, 1'b0, 8'h21, 32'hFFFF_FFFF, "mis_st_h", g, w);
        do_req(1'b0, SZ_WORD, 1'b0, 8'h22, 32'h0, "mis_ld_w", g, w);
        do_req(1'b0, SZ_ILL, 1'b0, 8'h24, 32'h0, "ill_ld", g, w);

        // reset during READ of a sub-word store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
        req_addr = 8'h30; req_wdata = 32'h0000_005A;
        w = 0;
        while (!req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (mem_wr_en || resp_valid) seen++;
        end
        chk("rstmid_ready_in_rst", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstmid_ready_after", 32'(req_ready), 32'd1);
        repeat (4) begin
            @(posedge clk); #1;
            if (mem_wr_en || resp_valid) seen++;
        end
        chk("rstmid_no_activity", 32'(seen), 32'd0);

        do_req(1'b1, SZ_WORD, 1'b0, 8'hFC, 32'hDEAD_BEEF, "b2b_st", g, w);
        do_req(1'b0, SZ_WORD, 1'b0, 8'hFC, 32'h0, "b2b_ld", g, w);
        chk("b2b_ld_val", g, 32'hDEAD_BEEF);
        chk("b2b_issue_gap", 32'(w), 32'd1);

        for (int k = 0; k < 300; k++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 9) == 0) ? SZ_ILL : 2'($urandom_range(0, 2));
            do_req(1'($urandom), sz, 1'($urandom), 8'($urandom_range(0, 63)),
                   $urandom, "rnd", g, w);
        end

        @(negedge clk);
        for (int i = 0; i < 256; i++) chk("ram_final", 32'(ram[i]), 32'(ref_ram[i]));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the byte-address width of the attached memory (256 bytes).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the word width (4 byte lanes).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  1  CPU access request.
REQ-006 req_ready  out  1  unit accepts a request this cycle.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 req_signed  in  1  sign-extend sub-word loads.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  DATA_W  store data, right-justified.
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_err  out  1  misaligned or illegal access, valid with resp_valid.
REQ-014 resp_rdata  out  DATA_W  load result, valid with resp_valid.
REQ-015 mem_addr  out  ADDR_W  word-aligned address to RAM.
REQ-016 mem_wr_en  out  1  RAM write enable.
REQ-017 mem_wr_data  out  DATA_W  RAM write word, byte lane 0 = lowest address.
REQ-018 mem_rd_data  in  DATA_W  RAM combinational read word at mem_addr.

Function
REQ-019 SHALL be a master for a word-wide, byte-addressed, little-endian RAM that has a combinational read and a write on the clock edge.
REQ-020 SHALL implement FSM states IDLE, READ, WRITE and RESP.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1; accepting captures all req_* fields.
REQ-022 mem_addr SHALL be {captured addr[ADDR_W-1:2], 2'b00} in every state.
REQ-023 The access is misaligned when: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
REQ-024 A misaligned access SHALL go IDLE->RESP with resp_err=1 and resp_rdata=0, and SHALL never assert mem_wr_en.
REQ-025 Load: IDLE->READ->RESP; READ registers mem_rd_data; resp_valid is asserted 2 cycles after accept.
REQ-026 Load extraction: select byte addr[1:0] or half addr[1]; zero-extend if req_signed=0, sign-extend if req_signed=1; a word load returns the full word.
REQ-027 Word store: IDLE->WRITE->RESP; WRITE drives mem_wr_en=1 with mem_wr_data=wdata; resp_valid 2 cycles after accept.
REQ-028 Sub-word store (read-modify-write): IDLE->READ->WRITE->RESP; READ captures the old word; WRITE writes the old word with only the addressed lane(s) replaced from wdata[7:0] or wdata[15:0]; resp_valid 3 cycles after accept.
REQ-029 mem_wr_en SHALL be 1 only in WRITE, for exactly one cycle per store.
REQ-030 resp_valid SHALL be 1 only in RESP, for one cycle; the FSM then returns to IDLE, and there is no response backpressure.
REQ-031 For a successful store, resp_err=0 and resp_rdata=0.
REQ-032 req_ready SHALL be 1 in the cycle after RESP, allowing back-to-back requests (a 3-cycle minimum issue interval for loads).
REQ-033 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-034 When rst_n=0 at a clock edge: state becomes IDLE; req_ready becomes 1; resp_valid, resp_err, mem_wr_en and resp_rdata become 0; the captured request fields become 0.
REQ-035 Reset mid-operation SHALL abort the access, with no write issued in the following cycle and no response.

Structure
REQ-036 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-037 The lane extract/sign-extend and store-merge logic SHALL be one combinational sub-module, ls_align.

Verification
REQ-038 RAM bytes 0x10..0x13 = 0x11,0x82,0x33,0xF4; load byte signed at 0x11 -> resp_rdata=0xFFFFFF82 at accept+2, and resp_err=0.
REQ-039 Same RAM contents, load half unsigned at 0x12 -> 0x0000F433; load word at 0x10 -> 0xF4338211.
REQ-040 Store byte 0xAB at 0x13 -> one mem_wr_en cycle at accept+2 with mem_wr_data=0xAB338211; then load word at 0x10 returns 0xAB338211.
REQ-041 Store half at 0x21, and load word at 0x22 -> resp_err=1 at accept+1, no mem_wr_en ever asserted, and the RAM is unchanged.
REQ-042 rst_n driven low during the READ state of a sub-word store -> no mem_wr_en, no resp_valid; req_ready=1 after reset is released.
REQ-043 Back-to-back: a word store of 0xDEADBEEF at 0xFC, followed immediately by a load word at 0xFC -> the load returns 0xDEADBEEF, with no accept while the unit is busy.
